calc_unit: RTL and testbench
============================

CALC_UNIT -- requirements
Module: calc_unit

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clk cycles per display digit slot.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 a  input  4  operand A (unsigned), latched from the operand-capture stage.
REQ-005 b  input  4  operand B (unsigned), latched from the operand-capture stage.
REQ-006 op  input  2  operation: 00 add, 01 sub, 10 mul, 11 reserved.
REQ-007 start  input  1  one-cycle request pulse from the debounced push-button path.
REQ-008 busy  output  1  operation in progress.
REQ-009 done  output  1  one-cycle completion strobe.
REQ-010 err  output  1  last accepted op was illegal.
REQ-011 result  output  8  registered result.
REQ-012 seg  output  7  seven-segment pattern {g,f,e,d,c,b,a}, active-low.
REQ-013 an  output  2  digit enables, active-low; an[0] = low-nibble digit.

Function
REQ-014 FSM states are IDLE, CALC and DONE; no other reachable state.
REQ-015 In IDLE, start=1 in cycle N latches a, b and op internally and enters CALC at N+1; busy=1 from N+1.
REQ-016 start is ignored while in CALC or DONE; it is neither queued nor allowed to alter latched operands.
REQ-017 Operand inputs changing after cycle N do not affect the operation in flight.
REQ-018 Add: result = {4'b0,A}+{4'b0,B}; CALC lasts 1 cycle; DONE at N+2.
REQ-019 Sub: result = ({4'b0,A}-{4'b0,B}) mod 256 (8-bit two's complement); CALC lasts 1 cycle; DONE at N+2.
REQ-020 Mul: shift-add, one multiplier bit per cycle, LSB first; CALC lasts exactly 4 cycles; DONE at N+5; result = A*B (max 225, no overflow).
REQ-021 Reserved op 11: CALC lasts 1 cycle; at DONE result=8'h00 and err=1.
REQ-022 result and err update only on entry to DONE; they hold between operations.
REQ-023 err clears on entry to DONE of the next legal op.
REQ-024 done=1 only in the DONE cycle; busy=1 in CALC and DONE; DONE returns to IDLE unconditionally next cycle.
REQ-025 start=1 in the DONE cycle is ignored; a new op is accepted from the following IDLE cycle.
REQ-026 Display: a free-running refresh counter counts 0..REFRESH_DIV-1 and wraps; each wrap toggles the digit select.
REQ-027 Select 0: an=2'b10, seg shows result[3:0]; select 1: an=2'b01, seg shows result[7:4]; hex glyphs 0-F.
REQ-028 The display runs independently of the FSM; the nibble shown always reflects the current result register.

Reset
REQ-029 rst=1 forces state IDLE, busy=0, done=0, err=0, result=8'h00, refresh counter=0, select=0, an=2'b10, seg=glyph "0" (7'b1000000), immediately and asynchronously.
REQ-030 rst asserted mid-operation aborts it; no done pulse is issued for the aborted op; latched operands are discarded.
REQ-031 First start is accepted in the first clock edge after rst deasserts.

Configuration
REQ-032 Macro MUL_EN: when defined, op 10 performs the multiply per REQ-020.
REQ-033 Without MUL_EN, op 10 is treated as reserved per REQ-021 (1-cycle CALC, result=8'h00, err=1) and no multiplier datapath is synthesized.

Verification
REQ-034 A=9, B=7, op=00, start pulse at N -> busy at N+1, done at N+2, result=8'h10, err=0.
REQ-035 A=3, B=5, op=01 -> result=8'hFE at N+2; display shows E on an=10 and F on an=01.
REQ-036 A=15, B=15, op=10, MUL_EN defined -> done at N+5, result=8'hE1; extra start pulses at N+2 ignored; without MUL_EN -> done at N+2, result=8'h00, err=1.
REQ-037 op=11 -> err=1, result=8'h00; then A=1, B=1, op=00 -> err=0, result=8'h02.
REQ-038 Mul in flight, rst pulsed at N+3 -> outputs at REQ-029 values, no done; next start accepted normally.
REQ-039 REFRESH_DIV=4, result=8'h5A -> an alternates 10/01 every 4 cycles with seg = glyph A / glyph 5.

Source files
------------

// File: rtl/calc_unit.sv
// Small 4-bit calculator: add, subtract and an optional shift-add multiply, with a
// two-digit multiplexed seven-segment readout of the 8-bit result. Define MUL_EN to build the multiplier.
module calc_unit #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] op,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] result,
    output logic [6:0] seg,
    output logic [1:0] an
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    state_e     state_q;
    op_e        op_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       busy_q;
    logic       done_q;
    logic       err_q;
    logic [7:0] result_q;

    logic [7:0] calc_res;
    logic       calc_err;
    logic       calc_last;

`ifdef MUL_EN
    logic [7:0] acc_q;
    logic [7:0] mcand_q;
    logic [3:0] mplier_q;
    logic [1:0] step_q;
    logic [7:0] acc_next;

    assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        calc_res  = 8'h00;
        calc_err  = 1'b1;
        calc_last = 1'b1;
        case (op_q)
            OP_ADD: begin
                calc_res = {4'b0000, a_q} + {4'b0000, b_q};
                calc_err = 1'b0;
            end
            OP_SUB: begin
                calc_res = {4'b0000, a_q} - {4'b0000, b_q};
                calc_err = 1'b0;
            end
`ifdef MUL_EN
            OP_MUL: begin
                calc_res  = acc_next;
                calc_err  = 1'b0;
                calc_last = (step_q == 2'd3);
            end
`endif
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            a_q      <= 4'h0;
            b_q      <= 4'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= 8'h00;
`ifdef MUL_EN
            acc_q    <= 8'h00;
            mcand_q  <= 8'h00;
            mplier_q <= 4'h0;
            step_q   <= 2'd0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op_e'(op);
                        busy_q  <= 1'b1;
                        state_q <= S_CALC;
`ifdef MUL_EN
                        acc_q    <= 8'h00;
                        mcand_q  <= {4'b0000, a};
                        mplier_q <= b;
                        step_q   <= 2'd0;
`endif
                    end
                end
                S_CALC: begin
                    if (calc_last) begin
                        result_q <= calc_res;
                        err_q    <= calc_err;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
`ifdef MUL_EN
                    // One multiplier bit per cycle, LSB first; the last bit is folded in by calc_res.
                    else begin
                        acc_q    <= acc_next;
                        mcand_q  <= {mcand_q[6:0], 1'b0};
                        mplier_q <= {1'b0, mplier_q[3:1]};
                        step_q   <= step_q + 2'd1;
                    end
`endif
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    logic [CNT_W-1:0] refresh_q;
    logic [CNT_W-1:0] refresh_d;
    logic             sel_q;
    logic             sel_d;

    always_comb begin
        refresh_d = refresh_q + CNT_W'(1);
        sel_d     = sel_q;
        if (refresh_q == CNT_MAX) begin
            refresh_d = '0;
            sel_d     = ~sel_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q <= '0;
            sel_q     <= 1'b0;
        end else begin
            refresh_q <= refresh_d;
            sel_q     <= sel_d;
        end
    end

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_glyph = 7'b1000000;
            4'h1:    hex_glyph = 7'b1111001;
            4'h2:    hex_glyph = 7'b0100100;
            4'h3:    hex_glyph = 7'b0110000;
            4'h4:    hex_glyph = 7'b0011001;
            4'h5:    hex_glyph = 7'b0010010;
            4'h6:    hex_glyph = 7'b0000010;
            4'h7:    hex_glyph = 7'b1111000;
            4'h8:    hex_glyph = 7'b0000000;
            4'h9:    hex_glyph = 7'b0010000;
            4'hA:    hex_glyph = 7'b0001000;
            4'hB:    hex_glyph = 7'b0000011;
            4'hC:    hex_glyph = 7'b1000110;
            4'hD:    hex_glyph = 7'b0100001;
            4'hE:    hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

    // Decoded straight from the result register so the digits track it with no extra lag.
    assign seg    = hex_glyph(sel_q ? result_q[7:4] : result_q[3:0]);
    assign an     = sel_q ? 2'b01 : 2'b10;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_calc_unit.sv
// Scoreboard bench for calc_unit: directed ops push expectations, a monitor checks each done strobe.
module tb_calc_unit;

    localparam int REFRESH_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic       start;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] result;
    logic [6:0] seg;
    logic [1:0] an;

    typedef struct {
        logic [7:0] res;
        logic       err;
        int         lat;
        int         issue;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    calc_unit #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .op     (op),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result),
        .seg    (seg),
        .an     (an)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    glyph = 7'h40;
            4'h1:    glyph = 7'h79;
            4'h2:    glyph = 7'h24;
            4'h3:    glyph = 7'h30;
            4'h4:    glyph = 7'h19;
            4'h5:    glyph = 7'h12;
            4'h6:    glyph = 7'h02;
            4'h7:    glyph = 7'h78;
            4'h8:    glyph = 7'h00;
            4'h9:    glyph = 7'h10;
            4'hA:    glyph = 7'h08;
            4'hB:    glyph = 7'h03;
            4'hC:    glyph = 7'h46;
            4'hD:    glyph = 7'h21;
            4'hE:    glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    // Monitor: every done strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("result", {24'd0, result}, {24'd0, e.res});
                check("err", {31'd0, err}, {31'd0, e.err});
                check("done_latency", cyc - e.issue, e.lat);
                check("busy_in_done", {31'd0, busy}, 32'd1);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_result"}, {24'd0, result}, 32'h00);
        check({tag, "_an"}, {30'd0, an}, 32'h2);
        check({tag, "_seg"}, {25'd0, seg}, 32'h40);
    endtask

    // Called at a falling edge; that cycle is N.
    task automatic do_op(input logic [3:0] ta, input logic [3:0] tb, input logic [1:0] top,
                         input logic [7:0] er, input logic ee, input int lat, input bit extra);
        exp_t e;
        int   k;
        a     = ta;
        b     = tb;
        op    = top;
        start = 1'b1;
        e.res = er;
        e.err = ee;
        e.lat = lat;
        e.issue = cyc;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = ~ta;
        b     = ~tb;
        op    = 2'b00;
        check("busy_at_n1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        if (extra) begin
            start = 1'b1;
            a     = 4'd1;
            b     = 4'd1;
            op    = 2'b00;
            @(negedge clk);
            start = 1'b0;
        end
        k = 0;
        while (k < 12 && busy !== 1'b0) begin
            @(negedge clk);
            k++;
        end
        check("op_finished", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_display(input logic [7:0] r);
        logic [1:0] prev;
        logic [1:0] cur;
        int         k;
        prev = an;
        k = 0;
        while (k < 10 && an == prev) begin
            @(negedge clk);
            k++;
        end
        check("disp_toggle_seen", {31'd0, an != prev}, 32'd1);
        cur = an;
        check("disp_an_onehot", {31'd0, (cur == 2'b10 || cur == 2'b01)}, 32'd1);
        for (int ph = 0; ph < 2; ph++) begin
            for (int j = 0; j < REFRESH_DIV; j++) begin
                check("disp_an", {30'd0, an}, {30'd0, cur});
                check("disp_seg", {25'd0, seg}, {25'd0, glyph(cur == 2'b10 ? r[3:0] : r[7:4])});
                @(negedge clk);
            end
            cur = ~cur;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        rst   = 1'b1;
        a     = 4'h0;
        b     = 4'h0;
        op    = 2'b00;
        start = 1'b0;
        #1;
        check_reset_values("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // First edge after reset release must accept the op.
        do_op(4'd9, 4'd7, 2'b00, 8'h10, 1'b0, 2, 1'b0);
        do_op(4'd3, 4'd5, 2'b01, 8'hFE, 1'b0, 2, 1'b0);
        check_display(8'hFE);

`ifdef MUL_EN
        do_op(4'd15, 4'd15, 2'b10, 8'hE1, 1'b0, 5, 1'b1);
`else
        do_op(4'd15, 4'd15, 2'b10, 8'h00, 1'b1, 2, 1'b1);
`endif

        do_op(4'd4, 4'd2, 2'b11, 8'h00, 1'b1, 2, 1'b0);
        a = 4'd7;
        b = 4'd7;
        op = 2'b01;
        repeat (3) @(negedge clk);
        check("hold_result", {24'd0, result}, 32'h00);
        check("hold_err", {31'd0, err}, 32'd1);

        do_op(4'd1, 4'd1, 2'b00, 8'h02, 1'b0, 2, 1'b0);
        check_display(8'h02);

`ifdef MUL_EN
        do_op(4'd9, 4'd10, 2'b10, 8'h5A, 1'b0, 5, 1'b0);
        check_display(8'h5A);
`endif

        // Multiply in flight, reset pulsed at N+3.
        a = 4'd15;
        b = 4'd15;
        op = 2'b10;
        start = 1'b1;
`ifndef MUL_EN
        e.res = 8'h00;
        e.err = 1'b1;
        e.lat = 2;
        e.issue = cyc;
        sb_q.push_back(e);
`endif
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_values("abort");
        @(negedge clk);
        rst = 1'b0;
        do_op(4'd2, 4'd3, 2'b00, 8'h05, 1'b0, 2, 1'b0);

        repeat (8) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
